// File: rtl/alu_mul_sequencer_if.sv
// Request/result and shared-ALU signals of the shift-and-add multiply sequencer.
// The master modport is the sequencer side; the slave modport is the execute stage and ALU.
interface alu_mul_sequencer_if #(
   parameter int n = 64
);
   logic         Start;
   logic [n-1:0] OpA;
   logic [n-1:0] OpB;
   logic         Busy;
   logic         Done;
   logic [n-1:0] Product;
   logic         AluReq;
   logic         AluGnt;
   logic [n-1:0] AluA;
   logic [n-1:0] AluB;
   logic [3:0]   AluCtrl;
   logic [n-1:0] AluW;
   logic         AluZero;

   modport master (
      input  Start, OpA, OpB, AluGnt, AluW, AluZero,
      output Busy, Done, Product, AluReq, AluA, AluB, AluCtrl
   );

   modport slave (
      output Start, OpA, OpB, AluGnt, AluW, AluZero,
      input  Busy, Done, Product, AluReq, AluA, AluB, AluCtrl
   );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Unsigned shift-and-add multiplier that borrows the shared ALU for every
// arithmetic step; the Zero flag on PassB of the multiplier ends the loop.
module alu_mul_sequencer #(
   parameter int n = 64
) (
   input  logic                CLK,
   input  logic                Reset,
   alu_mul_sequencer_if.master bus
);

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_LSL   = 4'b0011;
   localparam logic [3:0] ALU_LSR   = 4'b0100;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_ADD,
      S_SHIFT_M,
      S_SHIFT_Q,
      S_DONE
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic [n-1:0] mcand;
   logic [n-1:0] mplier;
   logic [n-1:0] acc;
   logic [n-1:0] product;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge CLK) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every output and next-state term gets a default first, so no path
   // through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      bus.AluReq  = 1'b0;
      bus.AluA    = '0;
      bus.AluB    = '0;
      bus.AluCtrl = ALU_AND;
      bus.Done    = 1'b0;
      bus.Busy    = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (bus.Start) state_nxt = S_CHECK;
         end
         S_CHECK: begin
            bus.AluReq  = 1'b1;
            bus.AluCtrl = ALU_PASSB;
            bus.AluB    = mplier;
            if (bus.AluGnt) begin
               if (bus.AluZero)    state_nxt = S_DONE;
               else if (mplier[0]) state_nxt = S_ADD;
               else                state_nxt = S_SHIFT_M;
            end
         end
         S_ADD: begin
            bus.AluReq  = 1'b1;
            bus.AluCtrl = ALU_ADD;
            bus.AluA    = acc;
            bus.AluB    = mcand;
            if (bus.AluGnt) state_nxt = S_SHIFT_M;
         end
         S_SHIFT_M: begin
            bus.AluReq  = 1'b1;
            bus.AluCtrl = ALU_LSL;
            bus.AluA    = mcand;
            bus.AluB    = n'(1);
            if (bus.AluGnt) state_nxt = S_SHIFT_Q;
         end
         S_SHIFT_Q: begin
            bus.AluReq  = 1'b1;
            bus.AluCtrl = ALU_LSR;
            bus.AluA    = mplier;
            bus.AluB    = n'(1);
            if (bus.AluGnt) state_nxt = S_CHECK;
         end
         S_DONE: begin
            bus.Done  = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: the datapath registers are cleared by reset too, so an aborted
   // multiply leaves no stale operands or product behind.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         product <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.Start) begin
                  mcand  <= bus.OpA;
                  mplier <= bus.OpB;
                  acc    <= '0;
               end
            end
            // Product is captured on the way into DONE so it is valid with Done.
            S_CHECK:   if (bus.AluGnt && bus.AluZero) product <= acc;
            S_ADD:     if (bus.AluGnt) acc    <= bus.AluW;
            S_SHIFT_M: if (bus.AluGnt) mcand  <= bus.AluW;
            S_SHIFT_Q: if (bus.AluGnt) mplier <= bus.AluW;
            default: ;
         endcase
      end
   end

   assign bus.Product = product;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized bench for alu_mul_sequencer: a behavioural ALU serves the bus and
// each multiply is compared with a*b and the bit-count latency formula.
module tb_alu_mul_sequencer;

   localparam int N = 64;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   alu_mul_sequencer_if #(.n(N)) bus ();

   alu_mul_sequencer #(.n(N)) dut (
      .CLK   (clk),
      .Reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit prev_done = 1'b0;

   // Shared ALU as seen from the execute stage.
   always_comb begin
      case (bus.AluCtrl)
         4'b0000: bus.AluW = bus.AluA & bus.AluB;
         4'b0010: bus.AluW = bus.AluA + bus.AluB;
         4'b0011: bus.AluW = bus.AluA << bus.AluB[5:0];
         4'b0100: bus.AluW = bus.AluA >> bus.AluB[5:0];
         4'b0111: bus.AluW = bus.AluB;
         default: bus.AluW = '0;
      endcase
   end
   assign bus.AluZero = (bus.AluW == '0);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (!reset && bus.Done) check("done_single_cycle", 64'(prev_done), 64'd0);
      prev_done = bus.Done;
   end

   function automatic int exp_latency(input logic [63:0] b);
      int h = -1;
      int s = 2;
      for (int i = 0; i < 64; i++) if (b[i]) h = i;
      for (int i = 0; i <= h; i++) s += 3 + int'(b[i]);
      return s;
   endfunction

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"},    64'(bus.Busy),    64'd0);
      check({tag, "_done"},    64'(bus.Done),    64'd0);
      check({tag, "_alureq"},  64'(bus.AluReq),  64'd0);
      check({tag, "_alua"},    bus.AluA,         64'd0);
      check({tag, "_alub"},    bus.AluB,         64'd0);
      check({tag, "_aluctrl"}, 64'(bus.AluCtrl), 64'd0);
      check({tag, "_product"}, bus.Product,      64'd0);
   endtask

   // One multiply: Start in cycle 0, optional random/directed ALU stalls and
   // Start noise while busy; latency, product and Busy timing are checked.
   task automatic run_mul(input logic [63:0] a, input logic [63:0] b,
                          input int stall_pct, input int add_stall, input bit noisy);
      logic [63:0] exp_p;
      int  exp_c;
      int  cyc      = 0;
      int  stalls   = 0;
      int  add_left = add_stall;
      bit  seen     = 1'b0;
      bit  stall;
      exp_p = a * b;
      exp_c = exp_latency(b);
      @(negedge clk);
      check("idle_busy", 64'(bus.Busy), 64'd0);
      bus.Start  = 1'b1;
      bus.OpA    = a;
      bus.OpB    = b;
      bus.AluGnt = 1'b1;
      while (!seen && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         bus.Start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.OpA   = {$urandom, $urandom};
         bus.OpB   = {$urandom, $urandom};
         if (cyc == 1) check("busy_rise", 64'(bus.Busy), 64'd1);
         if (bus.Done) begin
            seen = 1'b1;
         end else begin
            stall = 1'b0;
            if (bus.AluReq) begin
               if (bus.AluCtrl == 4'b0010 && add_left > 0) begin
                  stall = 1'b1;
                  add_left--;
               end else if ($urandom_range(0, 99) < stall_pct) begin
                  stall = 1'b1;
               end
            end
            bus.AluGnt = ~stall;
            stalls += int'(stall);
         end
      end
      check("done_seen",    64'(seen),     64'd1);
      check("latency",      64'(cyc),      64'(exp_c + stalls));
      check("product",      bus.Product,   exp_p);
      check("busy_in_done", 64'(bus.Busy), 64'd1);
      bus.Start  = 1'b0;
      bus.AluGnt = 1'b1;
      @(negedge clk);
      check("busy_fall",    64'(bus.Busy),   64'd0);
      check("done_fall",    64'(bus.Done),   64'd0);
      check("alureq_idle",  64'(bus.AluReq), 64'd0);
      check("product_held", bus.Product,     exp_p);
      if (!seen) begin
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
      end
   endtask

   initial begin
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] mask;
      int          w;
      bus.Start  = 1'b0;
      bus.OpA    = '0;
      bus.OpB    = '0;
      bus.AluGnt = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b0;

      run_mul(64'd6, 64'd7, 0, 0, 1'b0);
      run_mul(64'd123, 64'd0, 0, 0, 1'b0);
      run_mul(64'h8000_0000_0000_0000, 64'd2, 0, 0, 1'b0);
      run_mul('1, '1, 0, 0, 1'b0);
      run_mul(64'd6, 64'd7, 0, 5, 1'b0);
      run_mul(64'd6, 64'd7, 0, 0, 1'b1);

      // Reset in cycle 6 of a 6x7 multiply discards it without a Done.
      @(negedge clk);
      bus.Start = 1'b1;
      bus.OpA   = 64'd6;
      bus.OpB   = 64'd7;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         bus.Start = 1'b0;
         if (c == 6) reset = 1'b1;
      end
      @(negedge clk);
      check_outputs_zero("midreset");
      reset = 1'b0;
      @(negedge clk);
      check("midreset_no_done", 64'(bus.Done), 64'd0);
      run_mul(64'd3, 64'd5, 0, 0, 1'b0);

      for (int k = 0; k < 16; k++) begin
         w    = $urandom_range(1, 64);
         mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
         a    = {$urandom, $urandom};
         b    = {$urandom, $urandom} & mask;
         run_mul(a, b, $urandom_range(0, 40), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
